// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M sequencer: shift-add multiply and restoring divide, one step per cycle.
// Stalls the pipeline while running and emits a single-cycle result pulse with its rd.
module ex_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs1_val_i,
    input  logic [WIDTH-1:0] rs2_val_i,
    input  logic [4:0]       rd_in_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic [4:0]       result_rd_o,
    output logic             busy_o,
    output logic             stall_o
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [4:0]           rd_q, rd_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic             accept, is_div, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
    logic             div_zero, div_ovf, last_step;
    logic [WIDTH-1:0] rs1_abs, rs2_abs, fast_res;

    always_comb begin
        accept     = (state_q == StIdle) && start_i && !flush_i;
        is_div     = op_i[2];
        rs1_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        rs2_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        rs1_neg    = rs1_signed && rs1_val_i[WIDTH-1];
        rs2_neg    = rs2_signed && rs2_val_i[WIDTH-1];
        rs1_abs    = rs1_neg ? -rs1_val_i : rs1_val_i;
        rs2_abs    = rs2_neg ? -rs2_val_i : rs2_val_i;
        div_zero   = (rs2_val_i == '0);
        // Signed overflow: most-negative dividend over -1
        div_ovf    = !op_i[0] && (rs1_val_i == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_val_i == '1);
        if (div_zero) begin
            fast_res = op_i[1] ? rs1_val_i : '1;
        end else begin
            fast_res = op_i[1] ? '0 : rs1_val_i;
        end
        last_step  = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Multiply step: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, mul_prod;
    logic [WIDTH-1:0]     mul_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        mul_prod = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q == 3'd0) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];
    end

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     div_quo, div_rem, div_res;

    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, a_q};
        div_ge    = !div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
        div_quo   = div_next[WIDTH-1:0];
        div_rem   = div_next[2*WIDTH-1:WIDTH];
        if (op_q[1]) begin
            div_res = neg_q ? -div_rem : div_rem;
        end else begin
            div_res = neg_q ? -div_quo : div_quo;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        a_d      = a_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d  = op_i;
                    rd_d  = rd_in_i;
                    cnt_d = '0;
                    // Remainder follows the dividend; everything else the product of signs
                    neg_d = (is_div && op_i[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
                    if (is_div) begin
                        if (div_zero || div_ovf) begin
                            result_d = fast_res;
                            state_d  = StDone;
                        end else begin
                            a_d     = rs2_abs;
                            acc_d   = {{WIDTH{1'b0}}, rs1_abs};
                            state_d = StDiv;
                        end
                    end else begin
                        a_d     = rs1_abs;
                        acc_d   = {{WIDTH{1'b0}}, rs2_abs};
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        result_d = mul_res;
                        state_d  = StDone;
                    end
                end
            end
            StDiv: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        result_d = div_res;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        busy_o         = (state_q == StMul) || (state_q == StDiv);
        stall_o        = accept || busy_o;
        result_valid_o = (state_q == StDone) && !flush_i;
        result_o       = result_q;
        result_rd_o    = rd_q;
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: issued ops push expected {result, rd, cycle};
// a monitor pops and compares on every result_valid pulse.
module tb_ex_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_val_i;
    logic [31:0] rs2_val_i;
    logic [4:0]  rd_in_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic [4:0]  result_rd_o;
    logic        busy_o;
    logic        stall_o;

    ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .op_i           (op_i),
        .rs1_val_i      (rs1_val_i),
        .rs2_val_i      (rs2_val_i),
        .rd_in_i        (rd_in_i),
        .flush_i        (flush_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_rd_o    (result_rd_o),
        .busy_o         (busy_o),
        .stall_o        (stall_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one pop per completion pulse
    always @(negedge clk) begin
        #2;
        if (result_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got pulse expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("result_rd", {27'd0, result_rd_o}, {27'd0, e.rd});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, output int t);
        @(negedge clk);
        start_i   = 1'b1;
        flush_i   = 1'b0;
        op_i      = op;
        rs1_val_i = a;
        rs2_val_i = b;
        rd_in_i   = rd;
        #1;
        check("stall_accept", {31'd0, stall_o}, 32'd1);
        t = cyc;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit fast,
                         input bit hold);
        int   t;
        int   lat;
        exp_t e;
        lat = fast ? 1 : 33;
        drive_accept(op, a, b, rd, t);
        e.res = exp;
        e.rd  = rd;
        e.cyc = t + lat;
        sb.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (!hold) start_i = 1'b0;
            rs1_val_i = $urandom;
            rs2_val_i = $urandom;
            if (!hold) op_i = 3'($urandom);
            #1;
            check("stall_run", {31'd0, stall_o}, (k < lat) ? 32'd1 : 32'd0);
        end
        if (hold) begin
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    int t;

    initial begin
        rst = 1'b1; start_i = 1'b0; op_i = '0; rs1_val_i = '0; rs2_val_i = '0;
        rd_in_i = '0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", {31'd0, result_valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_rd", {27'd0, result_rd_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        rst = 1'b0;

        // Normal-path multiplies and divides, issued back-to-back
        issue(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0, 1'b0);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1'b0, 1'b0);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 1'b0, 1'b0);
        issue(3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 1'b0, 1'b0);
        issue(3'd1, 32'h80000000, 32'h80000000, 5'd9,  32'h40000000, 1'b0, 1'b0);
        issue(3'd4, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 1'b0, 1'b0);
        issue(3'd6, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(3'd5, 32'd100,      32'd7,        5'd12, 32'd14,       1'b0, 1'b0);
        issue(3'd7, 32'd100,      32'd7,        5'd13, 32'd2,        1'b0, 1'b0);
        issue(3'd4, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, 1'b0, 1'b0);
        issue(3'd6, 32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,        1'b0, 1'b0);

        // Fast paths
        issue(3'd5, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue(3'd6, 32'd5,        32'd0,        5'd17, 32'd5,        1'b1, 1'b0);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1'b1, 1'b0);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1'b1, 1'b0);

        // Flush mid-DIV, then a MUL accepted two cycles later
        drive_accept(3'd4, 32'd1000, 32'd3, 5'd20, t);
        @(negedge clk);
        start_i = 1'b0;
        repeat (t + 10 - cyc) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check("flush_stall", {31'd0, stall_o}, 32'd0);
        check("flush_busy", {31'd0, busy_o}, 32'd0);
        check("flush_idle_cycle", cyc, t + 11);
        issue(3'd0, 32'd12, 32'd12, 5'd21, 32'd144, 1'b0, 1'b0);

        // Flush during DONE suppresses the pulse
        drive_accept(3'd0, 32'd3, 32'd5, 5'd22, t);
        @(negedge clk);
        start_i = 1'b0;
        repeat (t + 33 - cyc) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check("flush_done_valid", {31'd0, result_valid_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0;

        // start with flush in IDLE is not accepted
        @(negedge clk);
        start_i = 1'b1;
        flush_i = 1'b1;
        #1;
        check("flush_start_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check("flush_start_busy", {31'd0, busy_o}, 32'd0);

        // start held through DONE yields one pulse
        issue(3'd3, 32'd65536, 32'd65536, 5'd23, 32'd1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Reset mid-MUL
        drive_accept(3'd0, 32'd9, 32'd9, 5'd24, t);
        @(negedge clk);
        start_i = 1'b0;
        repeat (t + 5 - cyc) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, result_valid_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        check("midrst_rd", {27'd0, result_rd_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
